// File: rtl/fft64_pkg.sv
// Shared definitions for the USFFT64 output framer: frame geometry and FSM/bank state types.
package fft64_pkg;

   localparam int unsigned FFT_N  = 64;
   localparam int unsigned FFT_AW = 6;
   localparam int unsigned FFT_DW = 19;

   // Capture side: waiting for RDY, writing a frame, or skipping a frame with no free bank
   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_CAPT = 2'd1,
      CAP_DROP = 2'd2
   } capt_state_e;

   // Drain side: waiting for a full bank, or issuing reads of a frame
   typedef enum logic {
      DRN_IDLE = 1'b0,
      DRN_SEND = 1'b1
   } drain_state_e;

   // Occupancy of one ping-pong bank
   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

endpackage

// File: rtl/fft64_pingpong_ram.sv
// Two-bank frame store: one write port, one synchronous read port whose output
// register holds its value whenever no read is issued.
module fft64_pingpong_ram
   import fft64_pkg::*;
#(
   parameter int unsigned DW = FFT_DW,
   parameter int unsigned AW = FFT_AW
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW:0]     waddr,
   input  logic [2*DW-1:0] wdata,
   input  logic            re,
   input  logic [AW:0]     raddr,
   output logic [2*DW-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** (AW + 1);

   logic [2*DW-1:0] mem [DEPTH];
   logic [2*DW-1:0] rdata_q;

   // Write on we; registered read only on re so the output doubles as a holding stage
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft64_out_framer.sv
// Captures USFFT64 result frames (any bin order) into a ping-pong store and
// re-streams them in natural bin order on a valid/ready port with frame overflow status.
module fft64_out_framer
   import fft64_pkg::*;
#(
   parameter int unsigned DW   = FFT_DW,
   parameter int unsigned AW   = FFT_AW,
   parameter int unsigned CNTW = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ED,
   input  logic            RDY,
   input  logic [AW-1:0]   ADDR,
   input  logic [DW-1:0]   DOR,
   input  logic [DW-1:0]   DOI,
   input  logic            OVF1,
   input  logic            OVF2,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_re,
   output logic [DW-1:0]   m_im,
   output logic [AW-1:0]   m_idx,
   output logic            m_last,
   output logic [1:0]      m_ovf,
   output logic [CNTW-1:0] drop_cnt
);

   // capture side
   capt_state_e     cs_q, cs_d;
   logic [AW-1:0]   wcnt_q, wcnt_d;
   logic            wptr_q, wptr_d;
   logic [1:0]      ovf_acc_q, ovf_acc_d;
   logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
   logic            ram_we;
   logic            set_full;
   logic [1:0]      cur_ovf;
   logic [1:0]      full_ovf;

   // bank bookkeeping
   bank_state_e     bank_q [2];
   bank_state_e     bank_d [2];
   logic [1:0]      bank_ovf_q [2];
   logic [1:0]      bank_ovf_d [2];
   logic            clr_empty;

   // drain side
   drain_state_e    ds_q, ds_d;
   logic            rptr_q, rptr_d;
   logic [AW-1:0]   ridx_q, ridx_d;
   logic            ram_re;
   logic            issue;
   logic            out_free;
   logic            s1_moves;
   logic            s1_free;
   logic [2*DW-1:0] ram_rdata;

   // read stage (data lives in the RAM output register)
   logic            s1_v_q, s1_v_d;
   logic [AW-1:0]   s1_idx_q, s1_idx_d;
   logic            s1_bank_q, s1_bank_d;
   logic [1:0]      s1_ovf_q, s1_ovf_d;

   // output register
   logic            m_valid_q, m_valid_d;
   logic [DW-1:0]   m_re_q, m_re_d;
   logic [DW-1:0]   m_im_q, m_im_d;
   logic [AW-1:0]   m_idx_q, m_idx_d;
   logic            m_last_q, m_last_d;
   logic [1:0]      m_ovf_q, m_ovf_d;
   logic            out_bank_q, out_bank_d;

   fft64_pingpong_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .waddr ({wptr_q, ADDR}),
      .wdata ({DOR, DOI}),
      .re    (ram_re),
      .raddr ({rptr_q, ridx_q}),
      .rdata (ram_rdata)
   );

   // Capture FSM: advances only on ED cycles; frame length is fixed at N bins
   always_comb begin
      cs_d       = cs_q;
      wcnt_d     = wcnt_q;
      wptr_d     = wptr_q;
      ovf_acc_d  = ovf_acc_q;
      drop_cnt_d = drop_cnt_q;
      ram_we     = 1'b0;
      set_full   = 1'b0;
      cur_ovf    = {OVF2, OVF1};
      full_ovf   = ovf_acc_q | cur_ovf;
      if (ED) begin
         unique case (cs_q)
            CAP_IDLE: begin
               if (RDY) begin
                  wcnt_d = AW'(1);
                  if (bank_q[wptr_q] == BANK_EMPTY) begin
                     ram_we    = 1'b1;
                     ovf_acc_d = cur_ovf;
                     cs_d      = CAP_CAPT;
                  end else begin
                     cs_d = CAP_DROP;
                     if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                     end
                  end
               end
            end
            CAP_CAPT: begin
               ram_we    = 1'b1;
               wcnt_d    = wcnt_q + 1'b1;
               ovf_acc_d = full_ovf;
               if (wcnt_q == '1) begin
                  set_full = 1'b1;
                  wptr_d   = ~wptr_q;
                  cs_d     = CAP_IDLE;
               end
            end
            CAP_DROP: begin
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q == '1) begin
                  cs_d = CAP_IDLE;
               end
            end
            default: cs_d = CAP_IDLE;
         endcase
      end
   end

   // Bank occupancy: capture fills the write bank, the last output transfer empties its bank
   always_comb begin
      bank_d     = bank_q;
      bank_ovf_d = bank_ovf_q;
      clr_empty  = m_valid_q && m_ready && m_last_q;
      if (set_full) begin
         bank_d[wptr_q]     = BANK_FULL;
         bank_ovf_d[wptr_q] = full_ovf;
      end
      if (clr_empty) begin
         bank_d[out_bank_q] = BANK_EMPTY;
      end
   end

   // Drain: read issue, read stage and output register. The read pointer moves on
   // once bin N-1 is issued so the next frame's bin 0 can follow without a bubble;
   // the bank itself is released only when its last beat is accepted downstream.
   always_comb begin
      ds_d       = ds_q;
      rptr_d     = rptr_q;
      ridx_d     = ridx_q;
      ram_re     = 1'b0;
      s1_v_d     = s1_v_q;
      s1_idx_d   = s1_idx_q;
      s1_bank_d  = s1_bank_q;
      s1_ovf_d   = s1_ovf_q;
      m_valid_d  = m_valid_q;
      m_re_d     = m_re_q;
      m_im_d     = m_im_q;
      m_idx_d    = m_idx_q;
      m_last_d   = m_last_q;
      m_ovf_d    = m_ovf_q;
      out_bank_d = out_bank_q;

      out_free = !m_valid_q || m_ready;
      s1_moves = s1_v_q && out_free;
      s1_free  = !s1_v_q || out_free;

      if (s1_moves) begin
         m_valid_d  = 1'b1;
         m_re_d     = ram_rdata[2*DW-1 -: DW];
         m_im_d     = ram_rdata[DW-1:0];
         m_idx_d    = s1_idx_q;
         m_last_d   = (s1_idx_q == '1);
         m_ovf_d    = s1_ovf_q;
         out_bank_d = s1_bank_q;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      issue = s1_free && ((ds_q == DRN_SEND) || (bank_q[rptr_q] == BANK_FULL));
      if (issue) begin
         ram_re    = 1'b1;
         s1_v_d    = 1'b1;
         s1_idx_d  = ridx_q;
         s1_bank_d = rptr_q;
         s1_ovf_d  = bank_ovf_q[rptr_q];
         ridx_d    = ridx_q + 1'b1;
         if (ridx_q == '1) begin
            rptr_d = ~rptr_q;
            ds_d   = DRN_IDLE;
         end else begin
            ds_d = DRN_SEND;
         end
      end else if (s1_moves) begin
         s1_v_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         cs_q       <= CAP_IDLE;
         wcnt_q     <= '0;
         wptr_q     <= 1'b0;
         ovf_acc_q  <= '0;
         drop_cnt_q <= '0;
         for (int unsigned b = 0; b < 2; b++) begin
            bank_q[b]     <= BANK_EMPTY;
            bank_ovf_q[b] <= '0;
         end
         ds_q       <= DRN_IDLE;
         rptr_q     <= 1'b0;
         ridx_q     <= '0;
         s1_v_q     <= 1'b0;
         s1_idx_q   <= '0;
         s1_bank_q  <= 1'b0;
         s1_ovf_q   <= '0;
         m_valid_q  <= 1'b0;
         m_re_q     <= '0;
         m_im_q     <= '0;
         m_idx_q    <= '0;
         m_last_q   <= 1'b0;
         m_ovf_q    <= '0;
         out_bank_q <= 1'b0;
      end else begin
         cs_q       <= cs_d;
         wcnt_q     <= wcnt_d;
         wptr_q     <= wptr_d;
         ovf_acc_q  <= ovf_acc_d;
         drop_cnt_q <= drop_cnt_d;
         bank_q     <= bank_d;
         bank_ovf_q <= bank_ovf_d;
         ds_q       <= ds_d;
         rptr_q     <= rptr_d;
         ridx_q     <= ridx_d;
         s1_v_q     <= s1_v_d;
         s1_idx_q   <= s1_idx_d;
         s1_bank_q  <= s1_bank_d;
         s1_ovf_q   <= s1_ovf_d;
         m_valid_q  <= m_valid_d;
         m_re_q     <= m_re_d;
         m_im_q     <= m_im_d;
         m_idx_q    <= m_idx_d;
         m_last_q   <= m_last_d;
         m_ovf_q    <= m_ovf_d;
         out_bank_q <= out_bank_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_re     = m_re_q;
   assign m_im     = m_im_q;
   assign m_idx    = m_idx_q;
   assign m_last   = m_last_q;
   assign m_ovf    = m_ovf_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fft64_out_framer.sv
// Bench for fft64_out_framer: frame-level reference model (expected beat queue,
// held-frame count, drop count) driven by directed steps with random data/order.
module tb_fft64_out_framer;

   localparam int unsigned DW   = 19;
   localparam int unsigned AW   = 6;
   localparam int unsigned N    = 64;
   localparam int unsigned CNTW = 8;

   logic            CLK = 1'b0;
   logic            RST;
   logic            ED;
   logic            RDY;
   logic [AW-1:0]   ADDR;
   logic [DW-1:0]   DOR;
   logic [DW-1:0]   DOI;
   logic            OVF1;
   logic            OVF2;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_re;
   logic [DW-1:0]   m_im;
   logic [AW-1:0]   m_idx;
   logic            m_last;
   logic [1:0]      m_ovf;
   logic [CNTW-1:0] drop_cnt;

   fft64_out_framer #(
      .DW   (DW),
      .AW   (AW),
      .CNTW (CNTW)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ED       (ED),
      .RDY      (RDY),
      .ADDR     (ADDR),
      .DOR      (DOR),
      .DOI      (DOI),
      .OVF1     (OVF1),
      .OVF2     (OVF2),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_re     (m_re),
      .m_im     (m_im),
      .m_idx    (m_idx),
      .m_last   (m_last),
      .m_ovf    (m_ovf),
      .drop_cnt (drop_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic [AW-1:0] idx;
      logic          last;
      logic [1:0]    ovf;
   } beat_t;

   beat_t           exp_q [$];
   int              n_cmp = 0;
   int              n_fail = 0;
   int              held = 0;
   int              beats_seen = 0;
   logic [CNTW-1:0] exp_drop = '0;
   bit              pend = 1'b0;
   logic [DW-1:0]   pend_re [N];
   logic [DW-1:0]   pend_im [N];
   logic [1:0]      pend_ovf;
   bit              rand_ready = 1'b0;
   beat_t           mon_b;
   beat_t           mon_f;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] brev(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      for (int i = 0; i < int'(AW); i++) r[i] = v[int'(AW) - 1 - i];
      return r;
   endfunction

   // Output monitor: every displayed beat must be the model's next beat (this also covers stall stability)
   always @(negedge CLK) begin
      if (!RST && m_valid) begin
         chk("valid_has_beat", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            mon_b = {m_re, m_im, m_idx, m_last, m_ovf};
            mon_f = exp_q[0];
            chk("beat", 64'(mon_b), 64'(mon_f));
            if (m_ready) begin
               void'(exp_q.pop_front());
               beats_seen++;
               if (mon_f.last) held--;
            end
         end
      end
   end

   // One clock: completed frames enter the model at the edge that writes their last bin
   task automatic step();
      beat_t bt;
      @(posedge CLK);
      #1;
      if (pend) begin
         for (int i = 0; i < int'(N); i++) begin
            bt.re   = pend_re[i];
            bt.im   = pend_im[i];
            bt.idx  = AW'(i);
            bt.last = (i == int'(N) - 1);
            bt.ovf  = pend_ovf;
            exp_q.push_back(bt);
         end
         held++;
         pend = 1'b0;
      end
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         step();
         ED = 1'b0; RDY = 1'b0; ADDR = '0; DOR = '0; DOI = '0; OVF1 = 1'b0; OVF2 = 1'b0;
      end
   endtask

   // bitrev: ADDR in bit-reversed order with DOR=bin, DOI=-bin; otherwise shuffled order, random data
   task automatic send_frame(input bit bitrev, input bit gaps, input int ovf_at,
                             input logic [1:0] ovf_val, input int abort_at);
      logic [AW-1:0] ord [N];
      logic [AW-1:0] t;
      logic [1:0]    acc;
      bit            drop;
      int            j;
      for (int i = 0; i < int'(N); i++) ord[i] = bitrev ? brev(AW'(i)) : AW'(i);
      if (!bitrev) begin
         for (int i = int'(N) - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
         end
      end
      acc  = '0;
      drop = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (i == abort_at) return;
         if (gaps && (i % 2 == 1)) begin
            step();
            ED = 1'b0; RDY = 1'($urandom); ADDR = AW'($urandom); DOR = DW'($urandom);
            DOI = DW'($urandom); OVF1 = 1'($urandom); OVF2 = 1'($urandom);
         end
         step();
         if (i == 0) begin
            drop = (held >= 2);
            if (drop && exp_drop != '1) exp_drop = exp_drop + 1'b1;
         end
         ED   = 1'b1;
         RDY  = (i == 0);
         ADDR = ord[i];
         if (bitrev) begin
            DOR = DW'(ord[i]);
            DOI = -DW'(ord[i]);
         end else begin
            DOR = DW'($urandom);
            DOI = DW'($urandom);
         end
         {OVF2, OVF1} = (i == ovf_at) ? ovf_val : 2'b00;
         acc = acc | {OVF2, OVF1};
         pend_re[ord[i]] = DOR;
         pend_im[ord[i]] = DOI;
      end
      if (!drop) begin
         pend_ovf = acc;
         pend     = 1'b1;
      end
   endtask

   task automatic wait_drain(input string tag, input int bound);
      int c = 0;
      while ((pend || exp_q.size() != 0) && c < bound) begin
         idle(1);
         c++;
      end
      chk(tag, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset(input string tag);
      step();
      RST = 1'b1; ED = 1'b0; RDY = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      pend = 1'b0;
      exp_q.delete();
      held = 0;
      exp_drop = '0;
      chk({tag, "_valid"}, 64'(m_valid), 64'(0));
      chk({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int c;
      RST = 1'b1; ED = 1'b0; RDY = 1'b0; ADDR = '0; DOR = '0; DOI = '0;
      OVF1 = 1'b0; OVF2 = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;

      // reset state with idle inputs
      for (int k = 0; k < 10; k++) begin
         idle(1);
         chk("rst_valid", 64'(m_valid), 64'(0));
         chk("rst_last", 64'(m_last), 64'(0));
         chk("rst_idx", 64'(m_idx), 64'(0));
         chk("rst_re", 64'(m_re), 64'(0));
         chk("rst_im", 64'(m_im), 64'(0));
         chk("rst_ovf", 64'(m_ovf), 64'(0));
         chk("rst_drop", 64'(drop_cnt), 64'(0));
      end

      // one frame, bit-reversed arrival, then first-beat latency
      m_ready = 1'b1;
      send_frame(1'b1, 1'b0, -1, 2'b00, -1);
      idle(1);
      chk("lat_full_edge", 64'(m_valid), 64'(0));
      idle(1);
      chk("lat_plus1", 64'(m_valid), 64'(0));
      idle(1);
      chk("lat_plus2", 64'(m_valid), 64'(1));
      wait_drain("one_frame_drain", 200);

      // ED gaps and a single OVF1 cycle
      send_frame(1'b1, 1'b1, 17, 2'b01, -1);
      wait_drain("gap_frame_drain", 200);

      // random backpressure, two back-to-back frames
      rand_ready = 1'b1;
      send_frame(1'b0, 1'b0, -1, 2'b00, -1);
      send_frame(1'b0, 1'b0, 5, 2'b10, -1);
      wait_drain("bp_drain", 800);
      rand_ready = 1'b0;
      m_ready = 1'b1;
      idle(4);

      // overrun: three frames with the sink stalled
      m_ready = 1'b0;
      send_frame(1'b0, 1'b0, 3, 2'b11, -1);
      send_frame(1'b0, 1'b0, -1, 2'b00, -1);
      send_frame(1'b0, 1'b0, -1, 2'b00, -1);
      idle(8);
      chk("overrun_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("overrun_held", 64'(exp_q.size()), 64'(2 * N));
      base = beats_seen;
      m_ready = 1'b1;
      wait_drain("overrun_drain", 400);
      chk("overrun_beats", 64'(beats_seen - base), 64'(2 * N));
      idle(10);
      chk("overrun_no_extra", 64'(beats_seen - base), 64'(2 * N));

      // reset during capture at bin 30
      send_frame(1'b0, 1'b0, -1, 2'b00, 30);
      do_reset("rst_capt");
      send_frame(1'b0, 1'b0, 40, 2'b11, -1);
      wait_drain("after_rst_capt_drain", 200);

      // reset during drain around bin 10
      send_frame(1'b1, 1'b0, -1, 2'b00, -1);
      base = beats_seen;
      c = 0;
      while ((beats_seen - base) < 10 && c < 200) begin
         idle(1);
         c++;
      end
      chk("drain_reached_10", 64'(beats_seen - base), 64'(10));
      do_reset("rst_drain");
      idle(3);
      chk("rst_drain_quiet", 64'(m_valid), 64'(0));
      send_frame(1'b0, 1'b1, 0, 2'b10, -1);
      wait_drain("after_rst_drain_drain", 300);

      idle(5);
      chk("final_drop", 64'(drop_cnt), 64'(exp_drop));
      chk("final_valid", 64'(m_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
